// File: rtl/prbs_checker.sv
// Self-synchronising receive-side checker for the team LFSR stream.
// Seeks lock by predicting from received words, then free-runs the prediction and counts word errors.
module prbs_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_cnt,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  locked,
    output logic                  err_pulse,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [CNT_WIDTH-1:0]  word_count
);

    localparam int RUN_MAX = (LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT : LOSS_COUNT;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_COUNT);
    localparam logic [RUN_W-1:0] LOSS_RUN = RUN_W'(LOSS_COUNT);

    // Unknown widths fall back to s[0]^s[1]: the two extra s[0] taps cancel out.
    localparam int TAP1 = (DATA_WIDTH == 8)  ? 2 : (DATA_WIDTH == 16) ? 2 :
                          (DATA_WIDTH == 32) ? 10 : 1;
    localparam int TAP2 = (DATA_WIDTH == 8)  ? 3 : (DATA_WIDTH == 16) ? 3 :
                          (DATA_WIDTH == 32) ? 30 : 0;
    localparam int TAP3 = (DATA_WIDTH == 8)  ? 4 : (DATA_WIDTH == 16) ? 5 :
                          (DATA_WIDTH == 32) ? 31 : 0;

    typedef enum logic {SEEK, LOCKED} state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] exp_r, exp_n;
    logic [RUN_W-1:0]      run, run_n;
    logic                  err_n;
    logic                  inc_err;
    logic                  inc_word;

    function automatic logic [DATA_WIDTH-1:0] lfsr_next(input logic [DATA_WIDTH-1:0] s);
        logic fb;
        fb = s[0] ^ s[TAP1] ^ s[TAP2] ^ s[TAP3];
        return {fb, s[DATA_WIDTH-1:1]};
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= SEEK;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        exp_n    = exp_r;
        run_n    = run;
        err_n    = 1'b0;
        inc_err  = 1'b0;
        inc_word = 1'b0;
        if (in_valid) begin
            case (state)
                SEEK: begin
                    // An all-zero word predicts zero, and a zero prediction never matches.
                    exp_n = lfsr_next(in_data);
                    if (exp_r != '0 && in_data == exp_r) begin
                        if (run + 1'b1 == LOCK_RUN) begin
                            state_n = LOCKED;
                            run_n   = '0;
                        end else begin
                            run_n = run + 1'b1;
                        end
                    end else begin
                        run_n = '0;
                    end
                end
                LOCKED: begin
                    exp_n    = lfsr_next(exp_r);
                    inc_word = 1'b1;
                    if (in_data == exp_r) begin
                        run_n = '0;
                    end else begin
                        err_n   = 1'b1;
                        inc_err = 1'b1;
                        if (run + 1'b1 == LOSS_RUN) begin
                            state_n = SEEK;
                            run_n   = '0;
                            exp_n   = lfsr_next(in_data);
                        end else begin
                            run_n = run + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_r      <= '0;
            run        <= '0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            word_count <= '0;
        end else begin
            exp_r     <= exp_n;
            run       <= run_n;
            err_pulse <= err_n;
            if (clear_cnt) begin
                err_count  <= '0;
                word_count <= '0;
            end else begin
                if (inc_err)  err_count  <= sat_inc(err_count);
                if (inc_word) word_count <= sat_inc(word_count);
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side counterpart of the team's LFSR pseudo-random generator.
- Consumes a valid-qualified stream of LFSR words and self-synchronises to it without a shared seed.
- Once locked, counts word errors; declares loss of lock after repeated mismatches.
- Used on Ethernet/loopback bring-up paths to measure link integrity against a generator at the far end.

Parameters:
- DATA_WIDTH, 8, word width; taps defined for 8, 16 and 32, with a fallback for all other widths.
- LOCK_COUNT, 4, consecutive correct predictions needed to enter LOCKED (≥1).
- LOSS_COUNT, 8, consecutive mismatches in LOCKED that force a return to SEEK (≥1).
- CNT_WIDTH, 16, width of the error and word counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- clear_cnt  in  1  synchronous clear of err_count and word_count; lock state is unaffected
- in_valid  in  1  in_data holds a word this cycle
- in_data  in  DATA_WIDTH  received LFSR word
- locked  out  1  high while in LOCKED
- err_pulse  out  1  one-cycle pulse for each mismatched word while LOCKED
- err_count  out  CNT_WIDTH  saturating count of mismatched words while LOCKED
- word_count  out  CNT_WIDTH  saturating count of words checked while LOCKED

Behaviour:
- Sequence definition: next(s) = {fb, s[DATA_WIDTH-1:1]}, a right shift with feedback into the MSB.
  - fb for DATA_WIDTH 8: s[0]^s[2]^s[3]^s[4]
  - fb for 16: s[0]^s[2]^s[3]^s[5]
  - fb for 32: s[0]^s[10]^s[30]^s[31]
  - fb for any other width: s[0]^s[1]
- Internal state: expected register `exp` (DATA_WIDTH), run counter, FSM {SEEK, LOCKED}.
- Reset:
  - FSM=SEEK, exp=0, run=0.
  - locked=0, err_pulse=0, err_count=0, word_count=0.
  - Reset mid-stream discards lock immediately.
- All outputs are registered and update on the clk edge that samples in_valid=1, so latency is 1 cycle.
- in_valid=0: no state change; err_pulse=0.
- SEEK, on each valid word:
  - If exp ≠ 0 and in_data == exp: run++.
  - Otherwise run=0.
  - Always set exp = next(in_data), i.e. predict from received data.
  - in_data == 0 (LFSR lockup value): exp=0 and run=0.
  - When run reaches LOCK_COUNT: go to LOCKED, run=0, locked=1 on the same edge.
  - The first valid word after reset therefore never counts as a match; lock needs LOCK_COUNT+1 words.
- LOCKED, on each valid word:
  - Always set exp = next(exp). The prediction is free-running, so single-bit errors do not desynchronise.
  - word_count++ (saturating).
  - Match: run=0.
  - Mismatch: err_pulse=1, err_count++ (saturating at all-ones), run++.
  - When run reaches LOSS_COUNT: go to SEEK, locked=0, run=0, exp = next(in_data).
  - The mismatch that triggers loss is itself counted and pulsed.
- clear_cnt takes priority over an increment in the same cycle: counters go to 0 and that word is not counted.
- Counters hold their values across loss of lock; only rst or clear_cnt clears them.
- No backpressure; a word can be accepted every cycle.

Test Plan:
1. Lock-up, W=8: rst, then feed 0x01,0x80,0x40,0x20,0x10,0x88 back-to-back.
   - locked rises 1 cycle after 0x10 is sampled.
   - Then feed 0x88 → word_count=1, err_count=0.
2. Single error: from locked, continuing the sequence, replace one word with its bit0 flipped.
   - Exactly one err_pulse; err_count=1.
   - Subsequent correct words show no further errors; locked stays 1.
3. Loss of lock: after lock, feed 8 words of 0x55.
   - err_count=8.
   - locked falls on the edge sampling the 8th word.
   - Re-feeding a valid sequence relocks after 5 words.
4. Lockup/idle: feed 0x00 repeatedly in SEEK → locked stays 0.
   - Toggle in_valid with gaps in a valid sequence → lock timing counts only valid words.
5. Counters: with err_count=3, assert clear_cnt together with a mismatched word.
   - err_count=0 and word_count=0 after the edge; err_pulse still asserts.
   - With CNT_WIDTH=4, 20 errors → err_count saturates at 15.
6. Reset mid-lock: assert rst for 1 cycle while locked.
   - All outputs return to 0 the next cycle.
   - Relock needs LOCK_COUNT+1 valid words.
   - Repeat scenario 1 for DATA_WIDTH=16 and 32.
